// File: rtl/alu_md_sequencer.sv
// ALU control decoder plus RV32M multiply/divide sequencer (IDLE/RUN/DONE).
// Optional macro ALU_MD_DIV_EN: sequence divide-class ops; otherwise they flag illegal_o.
module alu_md_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic        mod,
    input  logic        i_ex_ac,
    input  logic [2:0]  funct,
    input  logic [1:0]  ALUop,
    input  logic [6:0]  funct_mul,
    output logic [3:0]  ALUcontrol,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        md_busy,
    output logic        md_done,
    output logic        stall,
    output logic        illegal_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    // Parameter sanity checks at elaboration
    if (MUL_CYCLES < 1 || MUL_CYCLES > 63 || (MUL_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_mul
        $error("alu_md_sequencer: MUL_CYCLES out of range for CNT_W");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_bad_div
        $error("alu_md_sequencer: DIV_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        md_op_q, md_op_d;
    logic              m_op_c;
    logic              div_blocked_c;
    logic [CNT_W-1:0]  load_c;

    assign m_op_c = (ALUop == 2'b10) && (funct_mul == 7'b0000001) && !i_ex_ac;

`ifdef ALU_MD_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    if ((DIV_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_div_w
        $error("alu_md_sequencer: DIV_CYCLES does not fit CNT_W");
    end

    assign div_blocked_c = 1'b0;
    assign load_c        = funct[2] ? DIV_LOAD : MUL_LOAD;
`else
    assign div_blocked_c = funct[2];
    assign load_c        = MUL_LOAD;
`endif

    // ALU operation code, decoded from current inputs in every state
    always_comb begin
        ALUcontrol = 4'b0000;
        case (ALUop)
            2'b00:   ALUcontrol = 4'b0000;
            2'b01:   ALUcontrol = 4'b1000;
            2'b10:   ALUcontrol = m_op_c ? 4'b1100 : {mod, funct};
            default: ALUcontrol = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            md_op_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
        end
    end

    // Next state and IDLE-phase combinational handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_op_d   = md_op_q;
        md_start  = 1'b0;
        stall     = 1'b0;
        illegal_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                illegal_o = valid_i && m_op_c && div_blocked_c;
                if (valid_i && m_op_c && !flush_i && !div_blocked_c) begin
                    md_start = 1'b1;
                    stall    = 1'b1;
                    md_op_d  = funct;
                    cnt_d    = load_c;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                // Inputs ignored so the retiring instruction cannot restart
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign md_busy = (state_q == S_RUN);
    assign md_done = (state_q == S_DONE);
    assign md_op   = md_op_q;

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Scoreboard bench for alu_md_sequencer: timeline reference model feeds a queue,
// a negedge monitor compares every cycle.
module tb_alu_md_sequencer;

    localparam int unsigned MUL_CYC = 4;
    localparam int unsigned DIV_CYC = 32;
`ifdef ALU_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       valid_i, flush_i, mod, i_ex_ac;
    logic [2:0] funct;
    logic [1:0] ALUop;
    logic [6:0] funct_mul;
    logic [3:0] ALUcontrol;
    logic       md_start, md_busy, md_done, stall, illegal_o;
    logic [2:0] md_op;

    alu_md_sequencer #(.MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i), .mod(mod),
        .i_ex_ac(i_ex_ac), .funct(funct), .ALUop(ALUop), .funct_mul(funct_mul),
        .ALUcontrol(ALUcontrol), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
        .md_done(md_done), .stall(stall), .illegal_o(illegal_o)
    );

    typedef struct {
        int         cyc;
        logic [3:0] alu;
        logic       start, stl, busy, done, ill;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: one in-flight op described by accept cycle and length
    int         cyc   = 0;
    bit         act   = 0;
    int         t_acc = 0;
    int         n_len = 0;
    logic [2:0] op_m  = 3'b000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic v, input logic fl, input logic md, input logic ie,
                        input logic [2:0] f, input logic [1:0] aop, input logic [6:0] fm,
                        input logic rs);
        exp_t e;
        int   k;
        int   ph;
        bit   mop, ill, acc;
        @(posedge clk);
        #1;
        valid_i = v; flush_i = fl; mod = md; i_ex_ac = ie;
        funct = f; ALUop = aop; funct_mul = fm; reset = rs;

        ph = 0;
        if (act) begin
            k = cyc - t_acc;
            if (k >= 1 && k <= n_len) ph = 1;
            else if (k == n_len + 1) ph = 2;
        end
        mop = (aop == 2'd2) && (fm == 7'd1) && !ie;
        ill = (ph == 0) && v && mop && f[2] && !DIV_EN;
        acc = (ph == 0) && v && mop && !fl && !(f[2] && !DIV_EN);

        e.cyc   = cyc;
        e.alu   = (aop == 2'd1) ? 4'd8 : (aop == 2'd2) ? (mop ? 4'd12 : {md, f}) : 4'd0;
        e.start = acc;
        e.stl   = acc || (ph == 1);
        e.busy  = (ph == 1);
        e.done  = (ph == 2);
        e.ill   = ill;
        e.op    = op_m;
        exp_q.push_back(e);

        if (rs) begin
            act  = 0;
            op_m = 3'b000;
        end else if (ph != 0 && (fl || ph == 2)) begin
            act = 0;
        end else if (acc) begin
            act   = 1;
            t_acc = cyc;
            n_len = f[2] ? int'(DIV_CYC) : int'(MUL_CYC);
            op_m  = f;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 2'd0, 7'd0, 0);
    endtask

    // Monitor: pop one expected record per cycle and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (ALUcontrol !== e.alu || md_start !== e.start || stall !== e.stl ||
                    md_busy !== e.busy || md_done !== e.done || illegal_o !== e.ill ||
                    md_op !== e.op) begin
                    n_fail++;
                    $display("FAIL cyc%0d outputs: got alu=%b start=%b stall=%b busy=%b done=%b ill=%b op=%b, want alu=%b start=%b stall=%b busy=%b done=%b ill=%b op=%b",
                             e.cyc, ALUcontrol, md_start, stall, md_busy, md_done, illegal_o, md_op,
                             e.alu, e.start, e.stl, e.busy, e.done, e.ill, e.op);
                end
            end
        end
    end

    // Watchdog: stall must never outlast the longest legal operation
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (stall === 1'b1) run++;
            else run = 0;
            if (run > int'(DIV_CYC) + 1) begin
                n_fail++;
                $display("FAIL expired wait: stall high for %0d consecutive cycles", run);
                run = 0;
            end
        end
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; mod = 1'b0; i_ex_ac = 1'b0;
        funct = 3'd0; ALUop = 2'd0; funct_mul = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ALUcontrol !== 4'b0000 || md_start !== 1'b0 || md_busy !== 1'b0 ||
            md_done !== 1'b0 || stall !== 1'b0 || illegal_o !== 1'b0 || md_op !== 3'b000) begin
            n_fail++;
            $display("FAIL reset state: alu=%b start=%b busy=%b done=%b stall=%b ill=%b op=%b",
                     ALUcontrol, md_start, md_busy, md_done, stall, illegal_o, md_op);
        end

        idle(2);
        // Plain decode
        step(1, 0, 1, 0, 3'b000, 2'b10, 7'b0100000, 0);
        step(1, 0, 1, 0, 3'b101, 2'b10, 7'b0100000, 0);
        step(1, 0, 0, 0, 3'b000, 2'b01, 7'd0, 0);
        step(1, 0, 0, 0, 3'b111, 2'b00, 7'd0, 0);
        step(1, 0, 1, 0, 3'b111, 2'b11, 7'd0, 0);
        // MUL
        step(1, 0, 0, 0, 3'b000, 2'b10, 7'b0000001, 0);
        idle(7);
        // DIV (sequenced or illegal depending on build)
        step(1, 0, 0, 0, 3'b100, 2'b10, 7'b0000001, 0);
        idle(36);
        // Immediate form suppresses M decode
        step(1, 0, 0, 1, 3'b000, 2'b10, 7'b0000001, 0);
        step(1, 0, 1, 1, 3'b011, 2'b10, 7'b0000001, 0);
        // Flush two cycles into a MULHU
        step(1, 0, 0, 0, 3'b011, 2'b10, 7'b0000001, 0);
        idle(1);
        step(0, 1, 0, 0, 3'b000, 2'b00, 7'd0, 0);
        idle(8);
        // Instruction held valid: back-to-back MULH, restart only after the IDLE gap
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 3'b001, 2'b10, 7'b0000001, 0);
        idle(8);
        // Reset mid-run
        step(1, 0, 0, 0, 3'b010, 2'b10, 7'b0000001, 0);
        idle(1);
        step(0, 0, 0, 0, 3'b000, 2'b00, 7'd0, 1);
        idle(8);
        // Flush on a valid M op in IDLE
        step(1, 1, 0, 0, 3'b000, 2'b10, 7'b0000001, 0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            logic [1:0] aop;
            logic [6:0] fm;
            int r;
            r   = int'($urandom_range(0, 9));
            aop = (r < 6) ? 2'd2 : 2'(r % 4);
            fm  = ($urandom_range(0, 3) != 0) ? 7'd1 : 7'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
                 $urandom_range(0, 7) == 0, 3'($urandom), aop, fm,
                 $urandom_range(0, 63) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md_sequencer.md
# alu_md_sequencer

Parametrised successor to the single-cycle ALU control decoder. Produces the 4-bit ALU control code for every instruction and sequences RV32M multiply/divide operations through an iterative multiply/divide unit, holding the core with a stall until the result is ready. Sits between the main control FSM and the datapath ALU/MD unit.

## Interface
Parameters:
- MUL_CYCLES, 4: cycles the MD unit needs for MUL/MULH/MULHSU/MULHU; legal range 1..63.
- DIV_CYCLES, 32: cycles for DIV/DIVU/REM/REMU; legal range 1..63.
- CNT_W, 6: iteration counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- valid_i  in  1  instruction in decode is valid
- flush_i  in  1  kill current instruction (trap/redirect)
- mod  in  1  funct7[5] (sub/sra selector)
- i_ex_ac  in  1  1 = I-type/immediate form, suppresses M decode
- funct  in  3  funct3
- ALUop  in  2  from main decoder: 00 add, 01 branch compare, 10 R/I-type, 11 reserved
- funct_mul  in  7  funct7
- ALUcontrol  out  4  ALU operation code
- md_start  out  1  one-cycle start pulse to MD unit
- md_op  out  3  registered funct3 of the running M op
- md_busy  out  1  MD operation in flight
- md_done  out  1  one-cycle pulse, MD result valid this cycle
- stall  out  1  hold PC/pipeline
- illegal_o  out  1  unsupported M op decoded

## Operation
- Combinational decode: ALUop 00 -> 0000; 01 -> 1000; 10 -> 1100 if M-op else {mod,funct}; 11 -> 0000.
- M-op = ALUop==10 & funct_mul==0000001 & i_ex_ac==0. Multiply class funct[2]=0, divide class funct[2]=1.
- States: IDLE, RUN, DONE.
- IDLE: if valid_i & M-op & !flush_i & !illegal_o -> md_start=1, stall=1, md_op<=funct, counter<=cycles-1 (per class), next RUN. Otherwise stall=0.
- RUN: stall=1, md_busy=1. counter==0 -> DONE, else counter-1.
- DONE: md_done=1, stall=0, md_busy=0; next IDLE unconditionally (inputs ignored, preventing restart of the same instruction).
- flush_i in RUN or DONE: next state IDLE, no md_done pulse afterwards; flush has priority over counter terminal.
- flush_i in IDLE suppresses md_start and stall.
- ALUcontrol stays decoded from current inputs in all states.
- valid_i low: no M sequencing; ALUcontrol still driven.

## Timing
- Reset: state IDLE, counter 0, md_op 000; md_start, md_busy, md_done, stall, illegal_o all 0 (with inputs idle).
- stall, md_start, illegal_o combinational from inputs in IDLE; md_busy, md_done, md_op registered-state outputs.
- M op accepted at cycle T: stall high T..T+N (N = MUL_CYCLES or DIV_CYCLES), md_done and stall low at T+N+1, instruction retires at T+N+1.
- Back-to-back M ops: second accepted no earlier than T+N+2 (one IDLE cycle after DONE).
- reset mid-RUN: IDLE next edge, no md_done.
- Counter never underflows; width overflow is a parameter error (elaboration assertion).

## Configuration
- ALU_MD_DIV_EN defined: divide class sequenced with DIV_CYCLES, illegal_o never asserts.
- Undefined: divide-class M op asserts illegal_o combinationally in IDLE with valid_i; no md_start, no stall, ALUcontrol still 1100; multiply class unaffected. DIV_CYCLES unused.

## Test plan
- Reset then ALUop=10, funct=000, mod=1, funct_mul=0100000 -> ALUcontrol=1000, stall=0; ALUop=01 -> 1000; ALUop=00/11 -> 0000.
- MUL (funct=000, funct_mul=0000001, i_ex_ac=0, valid_i=1) at T, MUL_CYCLES=4 -> md_start at T only, stall T..T+4, md_done at T+5, md_op=000.
- DIV (funct=100) with ALU_MD_DIV_EN, DIV_CYCLES=32 -> stall 33 cycles, md_done at T+33; without macro -> illegal_o=1, stall=0, md_start=0.
- Same encoding with i_ex_ac=1 -> ALUcontrol={mod,funct}, no md_start.
- flush_i at T+2 of MUL -> IDLE at T+3, stall=0, no md_done ever.
- Two MULs back-to-back, MUL_CYCLES=1 -> md_start at T and T+3, md_done at T+2 and T+5; reset asserted at T+1 of second run -> all outputs 0 next cycle.
